// File: rtl/interfaz_alu_uart_pkg.sv
// Shared types and constants for the UART <-> ALU frame controller.
// State encodings, ALU opcode values and default widths.
package interfaz_alu_uart_pkg;

   typedef enum logic [2:0] {
      ESPERA_OP1    = 3'd0,
      ESPERA_OP2    = 3'd1,
      ESPERA_OPCODE = 3'd2,
      CALCULO       = 3'd3,
      ENVIO         = 3'd4,
      ESPERA_TX     = 3'd5
   } estado_t;

   localparam logic [7:0] OP_ADD = 8'h20;
   localparam logic [7:0] OP_SUB = 8'h22;
   localparam logic [7:0] OP_AND = 8'h24;
   localparam logic [7:0] OP_OR  = 8'h25;
   localparam logic [7:0] OP_XOR = 8'h26;
   localparam logic [7:0] OP_SRA = 8'h03;
   localparam logic [7:0] OP_SRL = 8'h02;
   localparam logic [7:0] OP_NOR = 8'h27;

   localparam int ANCHO_DATO_DEF    = 8;
   localparam int ANCHO_TIMEOUT_DEF = 100000;

   // A disabled timeout (0 cycles) still needs a 1-bit counter.
   function automatic int ancho_timer(input int ciclos);
      return (ciclos < 1) ? 1 : $clog2(ciclos + 1);
   endfunction

endpackage

// File: rtl/interfaz_alu_uart_contador_timeout.sv
// Inter-byte idle timer: counts while enabled, pulses o_expira at the limit.
// Saturates at the limit instead of wrapping; TIMEOUT_CICLOS=0 disables it.
module contador_timeout
   import interfaz_alu_uart_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = ANCHO_TIMEOUT_DEF
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expira
);

   localparam int W      = ancho_timer(TIMEOUT_CICLOS);
   localparam int LIMITE = (TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0;
   localparam logic [W-1:0] LIMITE_W = W'(LIMITE);
   localparam logic ACTIVO = (TIMEOUT_CICLOS > 0);

   logic [W-1:0] cuenta;

   assign o_expira = ACTIVO && i_enable && (cuenta == LIMITE_W);

   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         cuenta <= '0;
      end else if (ACTIVO && i_enable && !o_expira) begin
         cuenta <= cuenta + 1'b1;
      end
   end

endmodule

// File: rtl/interfaz_alu_uart.sv
// Frame controller: gathers operand 1, operand 2 and opcode from the UART,
// feeds the ALU, and hands the low byte of its result to the transmitter.
module interfaz_alu_uart
   import interfaz_alu_uart_pkg::*;
#(
   parameter int CANT_BITS_DATO   = ANCHO_DATO_DEF,
   parameter int CANT_BUS_ENTRADA = ANCHO_DATO_DEF,
   parameter int CANT_BUS_SALIDA  = ANCHO_DATO_DEF,
   parameter int CANT_BITS_OPCODE = ANCHO_DATO_DEF,
   parameter int TIMEOUT_CICLOS   = ANCHO_TIMEOUT_DEF
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [CANT_BITS_DATO-1:0]   i_rx_data,
   input  logic                        i_rx_done,
   input  logic                        i_tx_done,
   input  logic [CANT_BUS_SALIDA-1:0]  i_resultado,
   output logic [CANT_BUS_ENTRADA-1:0] o_operando_1,
   output logic [CANT_BUS_ENTRADA-1:0] o_operando_2,
   output logic [CANT_BITS_OPCODE-1:0] o_opcode,
   output logic [CANT_BITS_DATO-1:0]   o_tx_data,
   output logic                        o_tx_start,
   output logic                        o_overrun,
   output logic                        o_timeout,
   output logic [2:0]                  o_estado
);

   estado_t estado;
   logic    timer_en;
   logic    timer_clr;
   logic    expira;
   logic    ocupado;

   assign o_estado  = estado;
   assign timer_en  = (estado == ESPERA_OP2) || (estado == ESPERA_OPCODE);
   assign timer_clr = i_rx_done || !timer_en;
   assign ocupado   = (estado == CALCULO) || (estado == ENVIO) ||
                      (estado == ESPERA_TX);

   contador_timeout #(
      .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
   ) u_timer (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (timer_clr),
      .i_enable (timer_en),
      .o_expira (expira)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         estado       <= ESPERA_OP1;
         o_operando_1 <= '0;
         o_operando_2 <= '0;
         o_opcode     <= '0;
         o_tx_data    <= '0;
         o_tx_start   <= 1'b0;
         o_overrun    <= 1'b0;
         o_timeout    <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         o_timeout  <= 1'b0;
         if (i_rx_done && ocupado) begin
            o_overrun <= 1'b1;
         end
         case (estado)
            ESPERA_OP1: begin
               if (i_rx_done) begin
                  o_operando_1 <= CANT_BUS_ENTRADA'(i_rx_data);
                  estado       <= ESPERA_OP2;
               end
            end
            ESPERA_OP2: begin
               if (i_rx_done) begin
                  o_operando_2 <= CANT_BUS_ENTRADA'(i_rx_data);
                  estado       <= ESPERA_OPCODE;
               end else if (expira) begin
                  o_timeout <= 1'b1;
                  estado    <= ESPERA_OP1;
               end
            end
            ESPERA_OPCODE: begin
               if (i_rx_done) begin
                  o_opcode <= CANT_BITS_OPCODE'(i_rx_data);
                  estado   <= CALCULO;
               end else if (expira) begin
                  o_timeout <= 1'b1;
                  estado    <= ESPERA_OP1;
               end
            end
            CALCULO: begin
               o_tx_data <= i_resultado[CANT_BITS_DATO-1:0];
               estado    <= ENVIO;
            end
            ENVIO: begin
               o_tx_start <= 1'b1;
               estado     <= ESPERA_TX;
            end
            ESPERA_TX: begin
               if (i_tx_done) begin
                  estado <= ESPERA_OP1;
               end
            end
            default: estado <= ESPERA_OP1;
         endcase
      end
   end

endmodule

// File: tb/tb_interfaz_alu_uart.sv
// Scoreboard bench: UART modelled as pulses, ALU as a behavioural block.
// Expected bytes are queued at opcode time and popped on o_tx_start.
module tb_interfaz_alu_uart;
   import interfaz_alu_uart_pkg::*;

   localparam int T = 16;

   typedef struct {
      logic [7:0] dato;
      int         ciclo;
   } esperado_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_done = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] resultado;
   logic [7:0] op1, op2, opc, tx_data;
   logic       tx_start, overrun, timeout;
   logic [2:0] estado;

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int obs_to = 0;
   int exp_to = 0;
   logic exp_ovr = 1'b0;
   int m_n = 0;
   int m_last = 0;
   logic [7:0] m_buf [3];
   esperado_t sb_q [$];
   logic [7:0] ops [8];

   interfaz_alu_uart #(
      .CANT_BITS_DATO   (8),
      .CANT_BUS_ENTRADA (8),
      .CANT_BUS_SALIDA  (8),
      .CANT_BITS_OPCODE (8),
      .TIMEOUT_CICLOS   (T)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_rx_data    (rx_data),
      .i_rx_done    (rx_done),
      .i_tx_done    (tx_done),
      .i_resultado  (resultado),
      .o_operando_1 (op1),
      .o_operando_2 (op2),
      .o_opcode     (opc),
      .o_tx_data    (tx_data),
      .o_tx_start   (tx_start),
      .o_overrun    (overrun),
      .o_timeout    (timeout),
      .o_estado     (estado)
   );

   function automatic logic [7:0] alu_ref(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SRA:  return 8'($signed(a) >>> b);
         OP_SRL:  return a >> b;
         OP_NOR:  return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   always_comb resultado = alu_ref(op1, op2, opc);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // Monitor: every transmit request must match the oldest expected byte.
   always @(negedge clk) begin
      esperado_t e;
      if (tx_start === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errs++;
            $display("FAIL tx_unexpected: got data %0h at cycle %0d expected none",
                     tx_data, cyc);
         end else begin
            e = sb_q.pop_front();
            if (tx_data !== e.dato || cyc != e.ciclo) begin
               errs++;
               $display("FAIL tx_byte: got %0h @%0d expected %0h @%0d",
                        tx_data, cyc, e.dato, e.ciclo);
            end
         end
      end
      if (timeout === 1'b1) obs_to++;
   end

   // Reference model: a frame is any three bytes whose inter-byte gaps
   // stay under T idle cycles; a longer gap discards the partial frame.
   task automatic send_byte(input logic [7:0] b, input int gap);
      esperado_t e;
      repeat (gap) @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      if (m_n > 0 && (cyc - m_last - 1) >= T) begin
         m_n = 0;
         exp_to++;
      end
      m_last = cyc;
      m_buf[m_n] = b;
      m_n++;
      if (m_n == 3) begin
         e.dato  = alu_ref(m_buf[0], m_buf[1], m_buf[2]);
         e.ciclo = cyc + 2;
         sb_q.push_back(e);
         m_n = 0;
      end
   endtask

   task automatic finish_frame(input bit ovr, input int wait_tx);
      repeat (2) @(negedge clk);
      chk("estado_espera_tx", 32'(estado), 32'd5);
      if (ovr) begin
         rx_data = 8'($urandom);
         rx_done = 1'b1;
         @(negedge clk);
         rx_done = 1'b0;
         exp_ovr = 1'b1;
         chk("overrun_set", 32'(overrun), 32'd1);
      end
      repeat (wait_tx) @(negedge clk);
      chk("estado_hold_tx", 32'(estado), 32'd5);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("estado_back_idle", 32'(estado), 32'd0);
      chk("operando_1", 32'(op1), 32'(m_buf[0]));
      chk("operando_2", 32'(op2), 32'(m_buf[1]));
      chk("opcode", 32'(opc), 32'(m_buf[2]));
   endtask

   task automatic pulse_tx();
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   initial begin
      int gaps [8];
      int frames;
      gaps = '{0, 1, 2, 5, 15, 16, 17, 20};
      ops  = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

      repeat (3) @(negedge clk);
      chk("rst_estado", 32'(estado), 32'd0);
      chk("rst_outputs", {op1, op2, opc, tx_data}, 32'd0);
      chk("rst_flags", {29'd0, tx_start, overrun, timeout}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame, then shift frames
      send_byte(8'h05, 0); send_byte(8'h03, 0); send_byte(8'h20, 0);
      finish_frame(1'b0, 2);
      send_byte(8'h80, 1); send_byte(8'h01, 0); send_byte(8'h03, 0);
      finish_frame(1'b0, 0);
      send_byte(8'h80, 0); send_byte(8'h01, 2); send_byte(8'h02, 1);
      finish_frame(1'b0, 1);

      // Timeout after first byte
      send_byte(8'h05, 0);
      repeat (T) @(negedge clk);
      chk("timeout_pulse", 32'(timeout), 32'd1);
      chk("timeout_estado", 32'(estado), 32'd0);
      chk("timeout_stale_op1", 32'(op1), 32'h05);
      @(negedge clk);
      chk("timeout_one_cycle", 32'(timeout), 32'd0);
      send_byte(8'h0A, 0); send_byte(8'h0F, 0); send_byte(8'h24, 0);
      finish_frame(1'b0, 0);

      // Byte arriving on the expiry cycle is still accepted
      send_byte(8'h07, 0); send_byte(8'h09, T - 1); send_byte(8'h22, 0);
      finish_frame(1'b0, 0);

      // Overrun is sticky
      send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h20, 0);
      finish_frame(1'b1, 1);
      send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h20, 0);
      finish_frame(1'b0, 0);
      chk("overrun_sticky", 32'(overrun), 32'd1);

      // tx_done in states 0-2 is ignored
      pulse_tx();
      chk("txd_idle_estado", 32'(estado), 32'd0);
      send_byte(8'h11, 0);
      pulse_tx();
      chk("txd_op2_estado", 32'(estado), 32'd1);
      send_byte(8'h22, 0);
      pulse_tx();
      chk("txd_opc_estado", 32'(estado), 32'd2);
      chk("txd_regs", {op1, op2}, 32'h1122);
      send_byte(8'h26, 0);
      finish_frame(1'b0, 0);

      // Reset wins over a concurrent opcode byte
      send_byte(8'h33, 0); send_byte(8'h44, 0);
      rx_data = 8'h20; rx_done = 1'b1; rst = 1'b1;
      @(negedge clk);
      rx_done = 1'b0; rst = 1'b0;
      m_n = 0;
      exp_ovr = 1'b0;
      chk("rst2_estado", 32'(estado), 32'd0);
      chk("rst2_outputs", {op1, op2, opc, tx_data}, 32'd0);
      chk("rst2_flags", {29'd0, tx_start, overrun, timeout}, 32'd0);
      repeat (5) @(negedge clk);

      // Random frames with random gaps and occasional overrun bytes
      frames = 0;
      while (frames < 40) begin
         send_byte(8'($urandom), gaps[$urandom_range(0, 7)]);
         if (m_n == 2 && $urandom_range(0, 1) == 1) begin
            send_byte(ops[$urandom_range(0, 7)], gaps[$urandom_range(0, 7)]);
         end
         if (m_n == 0 && sb_q.size() != 0) begin
            finish_frame($urandom_range(0, 5) == 0, $urandom_range(0, 3));
            frames++;
         end
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      chk("timeout_count", 32'(obs_to), 32'(exp_to));
      chk("overrun_final", 32'(overrun), 32'(exp_ovr));
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
